// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, write-back source codes, load funct3
// codes and the write-back FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// raw memory word and sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_low,
    input  logic [31:0]     word,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_low)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    // Misaligned halfwords ignore addr_low[0] rather than trapping.
    assign half_sel = addr_low[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the write-back source, waits for load data,
// and drives the register-file write port with x0 writes suppressed.
//
// state       | meaning
// ------------+------------------------------------------------------------
// WB_IDLE     | accepting; non-loads retire at the next edge
// WB_WAIT_MEM | load captured in pending regs, waiting for memRspValid
module writeback_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      inRd,
    input  logic            inRegWrite,
    input  logic [1:0]      inWbSel,
    input  logic [XLEN-1:0] inAluResult,
    input  logic [XLEN-1:0] inPcPlus4,
    input  logic [2:0]      inFunct3,
    input  logic [1:0]      inAddrLow,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRspData,
    output logic [4:0]      writeRegister,
    output logic [XLEN-1:0] writeData,
    output logic            regWrite,
    output logic            retire
);

    wb_state_e state, state_next;

    logic [4:0] pend_rd;
    logic       pend_reg_write;
    logic [2:0] pend_funct3;
    logic [1:0] pend_addr_low;

    logic            accept;
    logic            accept_load;
    logic            rsp_fire;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] aligned_data;

    logic [4:0]      write_register_d;
    logic [XLEN-1:0] write_data_d;
    logic            reg_write_d;
    logic            retire_d;

    assign inReady     = (state == WB_IDLE);
    assign accept      = inReady && inValid;
    assign accept_load = accept && (inWbSel == WB_SEL_LOAD);
    assign rsp_fire    = (state == WB_WAIT_MEM) && memRspValid;

    // Select code 11 falls through to the ALU result.
    assign sel_data = (inWbSel == WB_SEL_PC4) ? inPcPlus4 : inAluResult;

    load_align u_load_align (
        .funct3    (pend_funct3),
        .addr_low  (pend_addr_low),
        .word      (memRspData[31:0]),
        .load_data (aligned_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE:     if (accept_load) state_next = WB_WAIT_MEM;
            WB_WAIT_MEM: if (memRspValid) state_next = WB_IDLE;
            default:     state_next = WB_IDLE;
        endcase
    end

    always_comb begin
        write_register_d = writeRegister;
        write_data_d     = writeData;
        reg_write_d      = 1'b0;
        retire_d         = 1'b0;
        if (accept && !accept_load) begin
            write_register_d = inRd;
            write_data_d     = sel_data;
            reg_write_d      = inRegWrite && (inRd != 5'd0);
            retire_d         = 1'b1;
        end else if (rsp_fire) begin
            write_register_d = pend_rd;
            write_data_d     = aligned_data;
            reg_write_d      = pend_reg_write && (pend_rd != 5'd0);
            retire_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeRegister <= 5'd0;
            writeData     <= '0;
            regWrite      <= 1'b0;
            retire        <= 1'b0;
        end else begin
            writeRegister <= write_register_d;
            writeData     <= write_data_d;
            regWrite      <= reg_write_d;
            retire        <= retire_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rd        <= 5'd0;
            pend_reg_write <= 1'b0;
            pend_funct3    <= 3'd0;
            pend_addr_low  <= 2'd0;
        end else if (accept_load) begin
            pend_rd        <= inRd;
            pend_reg_write <= inRegWrite;
            pend_funct3    <= inFunct3;
            pend_addr_low  <= inAddrLow;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random
// instruction stream compared against an arithmetic reference model.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inRd;
    logic        inRegWrite;
    logic [1:0]  inWbSel;
    logic [31:0] inAluResult;
    logic [31:0] inPcPlus4;
    logic [2:0]  inFunct3;
    logic [1:0]  inAddrLow;
    logic        memRspValid;
    logic [31:0] memRspData;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic        retire;

    int passed = 0;
    int total  = 0;

    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    writeback_stage dut (
        .clk           (clk),
        .reset         (reset),
        .inValid       (inValid),
        .inReady       (inReady),
        .inRd          (inRd),
        .inRegWrite    (inRegWrite),
        .inWbSel       (inWbSel),
        .inAluResult   (inAluResult),
        .inPcPlus4     (inPcPlus4),
        .inFunct3      (inFunct3),
        .inAddrLow     (inAddrLow),
        .memRspValid   (memRspValid),
        .memRspData    (memRspData),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .retire        (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: select the byte/half by shifting, extend by xor/subtract.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned bsh;
        int unsigned hsh;
        logic [31:0] b;
        logic [31:0] h;
        bsh = 8 * int'(off);
        hsh = (off >= 2'd2) ? 16 : 0;
        b = (w >> bsh) & 32'h0000_00FF;
        h = (w >> hsh) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b100:  return b;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_wb(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] pc4);
        return (sel == 2'b10) ? pc4 : alu;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inValid     = 1'b0;
        memRspValid = 1'b0;
    endtask

    task automatic drive_instr(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [2:0] f3, input logic [1:0] off);
        inValid     = 1'b1;
        inWbSel     = sel;
        inRd        = rd;
        inRegWrite  = rw;
        inAluResult = alu;
        inPcPlus4   = pc4;
        inFunct3    = f3;
        inAddrLow   = off;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        drive_instr(2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 3'd0, 2'd0);
        inValid    = 1'b0;
        memRspData = 32'h0;
        #2;
        total++;
        if (writeRegister !== 5'd0 || writeData !== 32'h0 || regWrite !== 1'b0 ||
            retire !== 1'b0 || inReady !== 1'b1)
            $display("FAIL reset_state: wreg=%0d wdata=%h rw=%b ret=%b rdy=%b, need 0/0/0/0/1",
                     writeRegister, writeData, regWrite, retire, inReady);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        m_wreg  = 5'd0;
        m_wdata = 32'h0;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        drive_instr(2'b00, 5'd5, 1'b1, 32'h0000_1234, 32'hDEAD_0000, 3'd0, 2'd0);
        step();
        total++;
        if (regWrite !== 1'b1 || writeRegister !== 5'd5 || writeData !== 32'h1234 || retire !== 1'b1)
            $display("FAIL alu_write: rw=%b wreg=%0d wdata=%h ret=%b, need 1/5/00001234/1",
                     regWrite, writeRegister, writeData, retire);
        else passed++;
        idle_inputs();
        step();
        total++;
        if (regWrite !== 1'b0 || retire !== 1'b0 || writeData !== 32'h1234)
            $display("FAIL alu_pulse_width: rw=%b ret=%b wdata=%h, need 0/0/00001234",
                     regWrite, retire, writeData);
        else passed++;
        m_wreg  = 5'd5;
        m_wdata = 32'h1234;
    endtask

    task automatic test_x0_suppress();
        @(negedge clk);
        drive_instr(2'b10, 5'd0, 1'b1, 32'h5555_5555, 32'h0000_0100, 3'd0, 2'd0);
        step();
        total++;
        if (regWrite !== 1'b0 || retire !== 1'b1 || writeData !== 32'h100 || writeRegister !== 5'd0)
            $display("FAIL x0_suppress: rw=%b ret=%b wdata=%h wreg=%0d, need 0/1/00000100/0",
                     regWrite, retire, writeData, writeRegister);
        else passed++;
        idle_inputs();
        m_wreg  = 5'd0;
        m_wdata = 32'h100;
    endtask

    task automatic test_load_wait();
        int low_cycles;
        low_cycles = 0;
        @(negedge clk);
        drive_instr(2'b01, 5'd7, 1'b1, 32'h1111_1111, 32'h2222_2222, 3'b000, 2'd3);
        step();
        if (inReady === 1'b0) low_cycles++;
        total++;
        if (regWrite !== 1'b0 || retire !== 1'b0)
            $display("FAIL load_accept_quiet: rw=%b ret=%b, need 0/0", regWrite, retire);
        else passed++;
        inValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (inReady === 1'b0) low_cycles++;
        end
        memRspValid = 1'b1;
        memRspData  = 32'h80FF_FFFF;
        step();
        memRspValid = 1'b0;
        total++;
        if (low_cycles !== 3)
            $display("FAIL load_wait_stall: inReady low %0d cycles, need 3", low_cycles);
        else passed++;
        total++;
        if (writeData !== 32'hFFFF_FF80 || regWrite !== 1'b1 || writeRegister !== 5'd7 ||
            retire !== 1'b1 || inReady !== 1'b1)
            $display("FAIL load_wait_data: wdata=%h rw=%b wreg=%0d ret=%b rdy=%b, need ffffff80/1/7/1/1",
                     writeData, regWrite, writeRegister, retire, inReady);
        else passed++;
        m_wreg  = 5'd7;
        m_wdata = 32'hFFFF_FF80;
    endtask

    task automatic test_align_sweep();
        logic [2:0]  f3s  [4] = '{3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  offs [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [4] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_7F02, 32'h8001_7F02};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_instr(2'b01, 5'd9 + 5'(i), 1'b1, 32'h0, 32'h0, f3s[i], offs[i]);
            step();
            inValid     = 1'b0;
            memRspValid = 1'b1;
            memRspData  = 32'h8001_7F02;
            step();
            memRspValid = 1'b0;
            total++;
            if (writeData !== exps[i] || regWrite !== 1'b1)
                $display("FAIL align_sweep[%0d]: wdata=%h rw=%b, need %h/1", i, writeData, regWrite, exps[i]);
            else passed++;
            m_wreg  = 5'd9 + 5'(i);
            m_wdata = exps[i];
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        drive_instr(2'b01, 5'd12, 1'b1, 32'h0, 32'h0, 3'b010, 2'd0);
        step();
        inValid = 1'b0;
        total++;
        if (inReady !== 1'b0)
            $display("FAIL mid_load_stall: inReady=%b, need 0", inReady);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (inReady !== 1'b1 || regWrite !== 1'b0 || writeData !== 32'h0 || writeRegister !== 5'd0)
            $display("FAIL mid_load_async_reset: rdy=%b rw=%b wdata=%h wreg=%0d, need 1/0/0/0",
                     inReady, regWrite, writeData, writeRegister);
        else passed++;
        @(negedge clk);
        reset       = 1'b0;
        memRspValid = 1'b1;
        memRspData  = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (regWrite !== 1'b0 || retire !== 1'b0 || inReady !== 1'b1 || writeData !== 32'h0)
                $display("FAIL late_rsp_ignored[%0d]: rw=%b ret=%b rdy=%b wdata=%h, need 0/0/1/0",
                         i, regWrite, retire, inReady, writeData);
            else passed++;
        end
        memRspValid = 1'b0;
        m_wreg  = 5'd0;
        m_wdata = 32'h0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_instr(2'b00, 5'd1, 1'b1, 32'hA000_0001, 32'h0, 3'd0, 2'd0);
        step();
        total++;
        if (regWrite !== 1'b1 || writeRegister !== 5'd1 || writeData !== 32'hA000_0001)
            $display("FAIL b2b_alu1: rw=%b wreg=%0d wdata=%h, need 1/1/a0000001",
                     regWrite, writeRegister, writeData);
        else passed++;
        drive_instr(2'b01, 5'd2, 1'b1, 32'h0, 32'h0, 3'b001, 2'd2);
        step();
        total++;
        if (regWrite !== 1'b0 || retire !== 1'b0 || inReady !== 1'b0)
            $display("FAIL b2b_bubble: rw=%b ret=%b rdy=%b, need 0/0/0", regWrite, retire, inReady);
        else passed++;
        drive_instr(2'b10, 5'd3, 1'b1, 32'h0, 32'h0000_0404, 3'd0, 2'd0);
        memRspValid = 1'b1;
        memRspData  = 32'h7FFF_0000;
        step();
        memRspValid = 1'b0;
        total++;
        if (regWrite !== 1'b1 || writeRegister !== 5'd2 || writeData !== 32'h0000_7FFF || inReady !== 1'b1)
            $display("FAIL b2b_load: rw=%b wreg=%0d wdata=%h rdy=%b, need 1/2/00007fff/1",
                     regWrite, writeRegister, writeData, inReady);
        else passed++;
        step();
        inValid = 1'b0;
        total++;
        if (regWrite !== 1'b1 || writeRegister !== 5'd3 || writeData !== 32'h0000_0404 || retire !== 1'b1)
            $display("FAIL b2b_alu2: rw=%b wreg=%0d wdata=%h ret=%b, need 1/3/00000404/1",
                     regWrite, writeRegister, writeData, retire);
        else passed++;
        m_wreg  = 5'd3;
        m_wdata = 32'h0000_0404;
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] mem;
        logic [2:0]  f3;
        logic [1:0]  off;
        int          waits;
        int          errs;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 31));
            rw  = 1'($urandom_range(0, 1));
            alu = $urandom;
            pc4 = $urandom;
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            @(negedge clk);
            drive_instr(sel, rd, rw, alu, pc4, f3, off);
            step();
            inValid = 1'b0;
            if (sel == 2'b01) begin
                total++;
                if (regWrite !== 1'b0 || retire !== 1'b0 || inReady !== 1'b0 || writeData !== m_wdata) begin
                    errs++;
                    $display("FAIL rand_load_accept[%0d]: rw=%b ret=%b rdy=%b wdata=%h, need 0/0/0/%h",
                             n, regWrite, retire, inReady, writeData, m_wdata);
                end else passed++;
                waits = $urandom_range(0, 3);
                for (int w = 0; w < waits; w++) begin
                    memRspData = $urandom;
                    step();
                    total++;
                    if (regWrite !== 1'b0 || retire !== 1'b0 || inReady !== 1'b0) begin
                        errs++;
                        $display("FAIL rand_load_wait[%0d]: rw=%b ret=%b rdy=%b, need 0/0/0",
                                 n, regWrite, retire, inReady);
                    end else passed++;
                end
                mem = $urandom;
                memRspValid = 1'b1;
                memRspData  = mem;
                step();
                memRspValid = 1'b0;
                m_wdata = exp_load(f3, off, mem);
            end else begin
                m_wdata = exp_wb(sel, alu, pc4);
            end
            m_wreg = rd;
            total++;
            if (writeData !== m_wdata || writeRegister !== m_wreg || retire !== 1'b1 ||
                regWrite !== (rw && rd != 5'd0)) begin
                errs++;
                $display("FAIL rand_write[%0d]: wdata=%h wreg=%0d rw=%b ret=%b, need %h/%0d/%b/1",
                         n, writeData, writeRegister, regWrite, retire, m_wdata, m_wreg, rw && rd != 5'd0);
            end else passed++;
            // Stray responses while idle must be ignored.
            if ($urandom_range(0, 2) == 0) begin
                memRspValid = 1'($urandom_range(0, 1));
                memRspData  = $urandom;
                step();
                memRspValid = 1'b0;
                total++;
                if (regWrite !== 1'b0 || retire !== 1'b0 || writeData !== m_wdata ||
                    writeRegister !== m_wreg || inReady !== 1'b1) begin
                    errs++;
                    $display("FAIL rand_idle_hold[%0d]: rw=%b ret=%b wdata=%h wreg=%0d rdy=%b",
                             n, regWrite, retire, writeData, writeRegister, inReady);
                end else passed++;
            end
            if (errs > 10) break;
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0_suppress();
        test_load_wait();
        test_align_sweep();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
